// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: shares one data bus between two masters, one transaction in flight, per-transaction timeout.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin tie-break; default build uses fixed priority (M0 wins ties).
module data_bus_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              M0_Read,
  input  logic              M0_Write,
  input  logic [ADDR_W-1:0] M0_Addr,
  input  logic [DATA_W-1:0] M0_WrData,
  output logic [DATA_W-1:0] M0_RdData,
  output logic              M0_Done,
  output logic              M0_Err,
  input  logic              M1_Read,
  input  logic              M1_Write,
  input  logic [ADDR_W-1:0] M1_Addr,
  input  logic [DATA_W-1:0] M1_WrData,
  output logic [DATA_W-1:0] M1_RdData,
  output logic              M1_Done,
  output logic              M1_Err,
  output logic              Bus_Read,
  output logic              Bus_Write,
  output logic [ADDR_W-1:0] Bus_Addr,
  output logic [DATA_W-1:0] Bus_WrData,
  input  logic [DATA_W-1:0] Bus_RdData,
  input  logic              Bus_Done,
  output logic [1:0]        Grant
);

  localparam int CNT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
  localparam logic TO_EN = (TIMEOUT_CYCLES > 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BUSY0 = 3'd1,
    ST_BUSY1 = 3'd2,
    ST_COMP0 = 3'd3,
    ST_COMP1 = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_last_grant;
  logic              w_last_grant_nxt;
  logic              r_bus_read;
  logic              w_bus_read_nxt;
  logic              r_bus_write;
  logic              w_bus_write_nxt;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [ADDR_W-1:0] w_bus_addr_nxt;
  logic [DATA_W-1:0] r_bus_wrdata;
  logic [DATA_W-1:0] w_bus_wrdata_nxt;
  logic [1:0]        r_grant;
  logic [1:0]        w_grant_nxt;
  logic              r_m0_done;
  logic              w_m0_done_nxt;
  logic              r_m1_done;
  logic              w_m1_done_nxt;
  logic              r_m0_err;
  logic              w_m0_err_nxt;
  logic              r_m1_err;
  logic              w_m1_err_nxt;
  logic [DATA_W-1:0] r_m0_rddata;
  logic [DATA_W-1:0] w_m0_rddata_nxt;
  logic [DATA_W-1:0] r_m1_rddata;
  logic [DATA_W-1:0] w_m1_rddata_nxt;

  logic              w_req0;
  logic              w_req1;
  logic              w_pick1;
  logic              w_sel_read;
  logic              w_sel_write;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wrdata;
  logic              w_timeout;
  logic [CNT_W-1:0]  w_cnt_inc;

  assign w_req0 = M0_Read | M0_Write;
  assign w_req1 = M1_Read | M1_Write;

  // Arbitration winner; r_last_grant = 1 means M1 was granted last
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    w_pick1 = w_req1 & (~w_req0 | ~r_last_grant);
`else
    w_pick1 = w_req1 & ~w_req0;
`endif
  end

  // Command of the selected master; write wins when both read and write are raised
  always_comb begin
    w_sel_read   = 1'b0;
    w_sel_write  = 1'b0;
    w_sel_addr   = M0_Addr;
    w_sel_wrdata = M0_WrData;
    if (w_pick1) begin
      w_sel_read   = M1_Read & ~M1_Write;
      w_sel_write  = M1_Write;
      w_sel_addr   = M1_Addr;
      w_sel_wrdata = M1_WrData;
    end else begin
      w_sel_read   = M0_Read & ~M0_Write;
      w_sel_write  = M0_Write;
      w_sel_addr   = M0_Addr;
      w_sel_wrdata = M0_WrData;
    end
  end

  assign w_timeout = TO_EN & (r_cnt == TO_LAST);
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : (r_cnt + CNT_W'(1));

  // Next-state and next-output logic of the transaction FSM
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_last_grant_nxt = r_last_grant;
    w_bus_read_nxt   = r_bus_read;
    w_bus_write_nxt  = r_bus_write;
    w_bus_addr_nxt   = r_bus_addr;
    w_bus_wrdata_nxt = r_bus_wrdata;
    w_grant_nxt      = r_grant;
    w_m0_done_nxt    = 1'b0;
    w_m1_done_nxt    = 1'b0;
    w_m0_err_nxt     = 1'b0;
    w_m1_err_nxt     = 1'b0;
    w_m0_rddata_nxt  = r_m0_rddata;
    w_m1_rddata_nxt  = r_m1_rddata;
    case (r_state)
      ST_IDLE: begin
        w_grant_nxt     = 2'b00;
        w_bus_read_nxt  = 1'b0;
        w_bus_write_nxt = 1'b0;
        if (w_req0 | w_req1) begin
          w_state_nxt      = w_pick1 ? ST_BUSY1 : ST_BUSY0;
          w_grant_nxt      = w_pick1 ? 2'b10 : 2'b01;
          w_last_grant_nxt = w_pick1;
          w_cnt_nxt        = {CNT_W{1'b0}};
          w_bus_read_nxt   = w_sel_read;
          w_bus_write_nxt  = w_sel_write;
          w_bus_addr_nxt   = w_sel_addr;
          w_bus_wrdata_nxt = w_sel_wrdata;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY0, ST_BUSY1: begin
        if (Bus_Done | w_timeout) begin
          w_bus_read_nxt  = 1'b0;
          w_bus_write_nxt = 1'b0;
          w_grant_nxt     = 2'b00;
          if (r_state == ST_BUSY1) begin
            w_state_nxt   = ST_COMP1;
            w_m1_done_nxt = 1'b1;
            w_m1_err_nxt  = ~Bus_Done;
            if (!Bus_Done) begin
              w_m1_rddata_nxt = {DATA_W{1'b0}};
            end else if (r_bus_read) begin
              w_m1_rddata_nxt = Bus_RdData;
            end else begin
              w_m1_rddata_nxt = r_m1_rddata;
            end
          end else begin
            w_state_nxt   = ST_COMP0;
            w_m0_done_nxt = 1'b1;
            w_m0_err_nxt  = ~Bus_Done;
            if (!Bus_Done) begin
              w_m0_rddata_nxt = {DATA_W{1'b0}};
            end else if (r_bus_read) begin
              w_m0_rddata_nxt = Bus_RdData;
            end else begin
              w_m0_rddata_nxt = r_m0_rddata;
            end
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_COMP0, ST_COMP1: begin
        w_state_nxt     = ST_IDLE;
        w_grant_nxt     = 2'b00;
        w_bus_read_nxt  = 1'b0;
        w_bus_write_nxt = 1'b0;
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_grant_nxt     = 2'b00;
        w_bus_read_nxt  = 1'b0;
        w_bus_write_nxt = 1'b0;
      end
    endcase
  end

  // State and registered-output update with synchronous active-low reset
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_state      <= ST_IDLE;
      r_cnt        <= {CNT_W{1'b0}};
      r_last_grant <= 1'b1;
      r_bus_read   <= 1'b0;
      r_bus_write  <= 1'b0;
      r_bus_addr   <= {ADDR_W{1'b0}};
      r_bus_wrdata <= {DATA_W{1'b0}};
      r_grant      <= 2'b00;
      r_m0_done    <= 1'b0;
      r_m1_done    <= 1'b0;
      r_m0_err     <= 1'b0;
      r_m1_err     <= 1'b0;
      r_m0_rddata  <= {DATA_W{1'b0}};
      r_m1_rddata  <= {DATA_W{1'b0}};
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_bus_read   <= w_bus_read_nxt;
      r_bus_write  <= w_bus_write_nxt;
      r_bus_addr   <= w_bus_addr_nxt;
      r_bus_wrdata <= w_bus_wrdata_nxt;
      r_grant      <= w_grant_nxt;
      r_m0_done    <= w_m0_done_nxt;
      r_m1_done    <= w_m1_done_nxt;
      r_m0_err     <= w_m0_err_nxt;
      r_m1_err     <= w_m1_err_nxt;
      r_m0_rddata  <= w_m0_rddata_nxt;
      r_m1_rddata  <= w_m1_rddata_nxt;
    end
  end

  assign Bus_Read   = r_bus_read;
  assign Bus_Write  = r_bus_write;
  assign Bus_Addr   = r_bus_addr;
  assign Bus_WrData = r_bus_wrdata;
  assign Grant      = r_grant;
  assign M0_Done    = r_m0_done;
  assign M1_Done    = r_m1_done;
  assign M0_Err     = r_m0_err;
  assign M1_Err     = r_m1_err;
  assign M0_RdData  = r_m0_rddata;
  assign M1_RdData  = r_m1_rddata;

endmodule
